spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_peripheral.sv | 89 ++++++++
 tb/tb_spi_peripheral.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI write-only register file feeding the PWM block.
// Ports: clk/rst system clock and async active-high reset; sclk/copi/ncs raw
// SPI pins (asynchronous to clk); en_reg_out_*, en_reg_pwm_*, pwm_duty_cycle
// register outputs; wr_strobe one-clk pulse on each committed write.
module spi_peripheral #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
    logic                   r_sclk_hist, r_ncs_hist, r_armed;
    logic [15:0]            r_shift;
    logic [4:0]             r_cnt;
    logic                   w_sclk, w_copi, w_ncs;
    logic                   w_sclk_rise, w_ncs_fall, w_ncs_rise, w_capture, w_commit;
    logic [6:0]             w_addr;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_hist;
    assign w_ncs_fall  = ~w_ncs & r_ncs_hist;
    assign w_ncs_rise  = w_ncs & ~r_ncs_hist;
    // A frame interrupted by reset stays dead until ncs has been seen high again.
    // Gating on w_ncs also drops an sclk edge that coincides with the ncs rise.
    assign w_capture   = w_sclk_rise & ~w_ncs & r_armed;
    assign w_addr      = r_shift[14:8];
    assign w_commit    = w_ncs_rise && r_cnt == 5'd16 && r_shift[15] && w_addr <= 7'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
            r_sclk_hist <= 1'b0;
            r_ncs_hist  <= 1'b1;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_sclk_hist <= w_sclk;
            r_ncs_hist  <= w_ncs;
            r_armed     <= r_armed | w_ncs;
        end
    end

    // Counter saturates at 17 so any overrun frame can never look like 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_ncs_fall) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_capture) begin
            r_shift <= {r_shift[14:0], w_copi};
            r_cnt   <= (r_cnt == 5'd17) ? r_cnt : r_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            wr_strobe       <= 1'b0;
        end else begin
            en_reg_out_7_0  <= (w_commit && w_addr == 7'd0) ? r_shift[7:0] : en_reg_out_7_0;
            en_reg_out_15_8 <= (w_commit && w_addr == 7'd1) ? r_shift[7:0] : en_reg_out_15_8;
            en_reg_pwm_7_0  <= (w_commit && w_addr == 7'd2) ? r_shift[7:0] : en_reg_pwm_7_0;
            en_reg_pwm_15_8 <= (w_commit && w_addr == 7'd3) ? r_shift[7:0] : en_reg_pwm_15_8;
            pwm_duty_cycle  <= (w_commit && w_addr == 7'd4) ? r_shift[7:0] : pwm_duty_cycle;
            wr_strobe       <= w_commit;
        end
    end
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: randomized scoreboard bench for spi_peripheral.
module tb_spi_peripheral;
    localparam int S = 2;
    localparam int H = 4;

    typedef struct {
        int          addr;
        logic [7:0]  data;
        longint      cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe;

    int         checks = 0, failures = 0;
    longint     cyc = 0;
    exp_t       q[$];
    exp_t       e;
    logic [7:0] model [5];
    logic [7:0] st [5];
    logic [7:0] act [5];

    spi_peripheral #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        act[0] = en_reg_out_7_0;
        act[1] = en_reg_out_15_8;
        act[2] = en_reg_pwm_7_0;
        act[3] = en_reg_pwm_15_8;
        act[4] = pwm_duty_cycle;
        if (rst) begin
            for (int k = 0; k < 5; k++) st[k] = 8'h00;
            checks++;
            if (wr_strobe !== 1'b0) begin
                failures++;
                $display("FAIL reset_strobe got %b want 0", wr_strobe);
            end
        end else if (wr_strobe === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe at cycle %0d got 1 want 0", cyc);
            end else begin
                e = q.pop_front();
                st[e.addr] = e.data;
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL commit_latency addr %0d got cycle %0d want %0d", e.addr, cyc, e.cyc);
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (act[k] !== st[k]) begin
                failures++;
                $display("FAIL reg%0d at cycle %0d got %h want %h", k, cyc, act[k], st[k]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        copi = b;
        sclk = 1'b0;
        tick(H);
        sclk = 1'b1;
        tick(H);
    endtask

    // Drives n bits of w MSB-first; race adds an sclk rise together with the ncs rise.
    task automatic send(input logic [31:0] w, input int n, input int gap, input bit race);
        exp_t x;
        ncs = 1'b0;
        tick(H);
        for (int i = 0; i < n; i++) send_bit(w[n-1-i]);
        sclk = 1'b0;
        copi = 1'($urandom);
        tick(H);
        if (race) sclk = 1'b1;
        ncs = 1'b1;
        if (n == 16 && w[15] && w[14:8] <= 7'd4) begin
            x.addr = int'(w[14:8]);
            x.data = w[7:0];
            x.cyc  = cyc + S + 1;
            q.push_back(x);
            model[x.addr] = x.data;
        end
        if (race) begin
            tick(H);
            sclk = 1'b0;
        end
        tick(gap);
    endtask

    initial begin
        logic [31:0] w;
        logic [15:0] f;
        int n;
        for (int k = 0; k < 5; k++) model[k] = 8'h00;
        tick(3);
        rst = 1'b0;
        tick(4);
        send(32'h80FF, 16, 8, 0);
        send(32'h81A5, 16, 8, 0);
        send(32'h823C, 16, 8, 0);
        send(32'h830F, 16, 8, 0);
        send(32'h8480, 16, 8, 0);
        send(32'h0055, 16, 8, 0);
        send(32'h85AA, 16, 8, 0);
        send(32'hFF12, 16, 8, 0);
        send(32'h4008, 15, 8, 0);
        send(32'h10023, 17, 8, 0);
        send(32'h8133, 16, 8, 1);
        w = 32'h8477;
        ncs = 1'b0;
        tick(H);
        for (int i = 0; i < 8; i++) send_bit(w[15-i]);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) model[k] = 8'h00;
        tick(2);
        rst = 1'b0;
        for (int i = 8; i < 16; i++) send_bit(w[15-i]);
        sclk = 1'b0;
        tick(H);
        ncs = 1'b1;
        tick(8);
        send(32'h8433, 16, 8, 0);
        send(32'h8201, 16, 2, 0);
        send(32'h8202, 16, 8, 0);
        repeat (40) begin
            f = {($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(0, 127)),
                 8'($urandom)};
            case ($urandom_range(0, 5))
                0: begin n = 15; w = {17'd0, f[15:1]}; end
                1: begin n = 17; w = {15'd0, f, 1'($urandom)}; end
                default: begin n = 16; w = {16'd0, f}; end
            endcase
            if ($urandom_range(0, 1) != 0)
                repeat (3) begin
                    sclk = 1'b1;
                    tick(H);
                    sclk = 1'b0;
                    tick(H);
                end
            send(w, n, $urandom_range(2, 10), $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_commits got %0d want 0", q.size());
        end
        tick(4);
        act[0] = en_reg_out_7_0;
        act[1] = en_reg_out_15_8;
        act[2] = en_reg_pwm_7_0;
        act[3] = en_reg_pwm_15_8;
        act[4] = pwm_duty_cycle;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (act[k] !== model[k]) begin
                failures++;
                $display("FAIL final_reg%0d got %h want %h", k, act[k], model[k]);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
